// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the multi-port register file.
//   DEF_WIDTH / DEF_DEPTH / DEF_NUM_RD : default parameter values
//   ZERO_IDX                           : index of the optional hardwired-zero entry
//   addr_legal()                       : address-in-range check (DEPTH need not be 2^n)
package reg_file_pkg;

  localparam int          DEF_WIDTH  = 32;
  localparam int          DEF_DEPTH  = 8;
  localparam int          DEF_NUM_RD = 2;
  localparam int unsigned ZERO_IDX   = 0;

  // Addresses are zero-extended to 32 bits by the caller so one helper
  // serves every ADDR_W.
  function automatic logic addr_legal(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port of reg_file_mp.
//   clk, rst           : clock, async active-high reset
//   rd_en, rd_addr     : read strobe and address for this port
//   wr_en/addr/data    : write port, snooped for write-first bypass
//   mem                : storage array contents
//   rd_data/valid/err  : registered read response (1-cycle latency)
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int ZERO_REG = 0,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rd_en,
  input  logic [ADDR_W-1:0]            rd_addr,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic [DEPTH-1:0][WIDTH-1:0]  mem,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         rd_valid,
  output logic                         rd_err
);

  logic             legal;
  logic             is_zero;
  logic             bypass;
  logic [WIDTH-1:0] nxt_data;

  assign legal   = addr_legal(32'(rd_addr), DEPTH);
  assign is_zero = (ZERO_REG != 0) && (32'(rd_addr) == ZERO_IDX);
  // A matching write that is itself legal and not to the zero entry wins
  // over the stored value (write-first).
  assign bypass  = wr_en && (wr_addr == rd_addr) && legal && !is_zero;

  always_comb begin
    nxt_data = '0;
    if (legal && !is_zero) begin
      if (bypass) nxt_data = wr_data;
      else        nxt_data = mem[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_err   <= rd_en && !legal;
      if (rd_en) rd_data <= nxt_data;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file: one synchronous write port,
// NUM_RD registered read ports with write-first bypass, optional
// hardwired-zero entry 0, out-of-range address flags.
//   clk, rst          : clock, async active-high reset
//   wr_en/addr/data   : write port
//   rd_en, rd_addr    : per-port read strobes, packed addresses
//   rd_data           : packed read data, port p at [p*WIDTH +: WIDTH]
//   rd_valid, rd_err  : per-port response valid / out-of-range flag
//   wr_err            : last write addressed beyond DEPTH
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int NUM_RD   = DEF_NUM_RD,
  parameter  int ZERO_REG = 0,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0]  rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic [NUM_RD-1:0]        rd_err,
  output logic                     wr_err
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic                        wr_legal;
  logic                        wr_zero;

  assign wr_legal = addr_legal(32'(wr_addr), DEPTH);
  assign wr_zero  = (ZERO_REG != 0) && (32'(wr_addr) == ZERO_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && !wr_legal;
      if (wr_en && wr_legal && !wr_zero) mem[wr_addr] <= wr_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    reg_file_rd_port #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .clk      (clk),
      .rst      (rst),
      .rd_en    (rd_en[p]),
      .rd_addr  (rd_addr[p*ADDR_W +: ADDR_W]),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .mem      (mem),
      .rd_data  (rd_data[p*WIDTH +: WIDTH]),
      .rd_valid (rd_valid[p]),
      .rd_err   (rd_err[p])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp. Two instances share the stimulus:
// dut_a (DEPTH=8, ZERO_REG=0) and dut_b (DEPTH=6, ZERO_REG=1).
module tb_reg_file_mp;

  localparam int AW = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [1:0]  rd_en = '0;
  logic [5:0]  rd_addr = '0;

  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_valid_a, rd_valid_b, rd_err_a, rd_err_b;
  logic        wr_err_a, wr_err_b;

  always #5 clk = ~clk;

  reg_file_mp #(.WIDTH(32), .DEPTH(8), .NUM_RD(2), .ZERO_REG(0)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .rd_err(rd_err_a), .wr_err(wr_err_a));

  reg_file_mp #(.WIDTH(32), .DEPTH(6), .NUM_RD(2), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .rd_err(rd_err_b), .wr_err(wr_err_b));

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  vld;
    logic [1:0]  err;
    logic        werr;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int total = 0;
  int bad   = 0;

  // Reference model: plain arrays, index 0 = dut_a, 1 = dut_b.
  int          dep[2] = '{8, 6};
  int          zr[2]  = '{0, 1};
  logic [31:0] m_mem[2][8];
  logic [31:0] m_hold[2][2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) m_mem[d][i] = '0;
      for (int p = 0; p < 2; p++) m_hold[d][p] = '0;
    end
  endtask

  // Called just after the capturing edge while inputs are still stable.
  task automatic push_exp();
    exp_t e;
    int   a;
    int   wa;
    logic [31:0] v;
    wa = int'(wr_addr);
    for (int d = 0; d < 2; d++) begin
      e = '0;
      for (int p = 0; p < 2; p++) begin
        a = int'(rd_addr[p*AW +: AW]);
        if (rd_en[p]) begin
          if (a >= dep[d]) begin
            v = '0; e.err[p] = 1'b1;
          end else if (zr[d] != 0 && a == 0) v = '0;
          else if (wr_en && wa == a)         v = wr_data;
          else                                v = m_mem[d][a];
          m_hold[d][p] = v;
          e.vld[p] = 1'b1;
        end
        e.data[p*32 +: 32] = m_hold[d][p];
      end
      e.werr = wr_en && (wa >= dep[d]);
      if (d == 0) q_a.push_back(e); else q_b.push_back(e);
    end
    for (int d = 0; d < 2; d++)
      if (wr_en && wa < dep[d] && !(zr[d] != 0 && wa == 0)) m_mem[d][wa] = wr_data;
  endtask

  task automatic step(input logic we, input int wa, input logic [31:0] wd,
                      input logic [1:0] re, input int ra0, input int ra1);
    wr_en   = we;
    wr_addr = 3'(wa);
    wr_data = wd;
    rd_en   = re;
    rd_addr = {3'(ra1), 3'(ra0)};
    @(posedge clk);
    push_exp();
    #1;
  endtask

  // Monitor: pops one expected response per presented cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      chk("a.rd_data",  rd_data_a,  e.data);
      chk("a.rd_valid", 64'(rd_valid_a), 64'(e.vld));
      chk("a.rd_err",   64'(rd_err_a),   64'(e.err));
      chk("a.wr_err",   64'(wr_err_a),   64'(e.werr));
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      chk("b.rd_data",  rd_data_b,  e.data);
      chk("b.rd_valid", 64'(rd_valid_b), 64'(e.vld));
      chk("b.rd_err",   64'(rd_err_b),   64'(e.err));
      chk("b.wr_err",   64'(wr_err_b),   64'(e.werr));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1;
    chk("reset.rd_data_a",  rd_data_a, 64'h0);
    chk("reset.rd_valid_a", 64'(rd_valid_a), 64'h0);
    chk("reset.wr_err_b",   64'(wr_err_b), 64'h0);
    @(negedge clk); rst = 1'b0; #1;

    // Reset mid-operation: entry 3 loaded and read back, then async reset.
    step(1, 3, 32'hDEADBEEF, 2'b00, 0, 0);
    step(0, 0, 0, 2'b11, 3, 3);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("async_rst.rd_data_a",  rd_data_a, 64'h0);
    chk("async_rst.rd_valid_a", 64'(rd_valid_a), 64'h0);
    chk("async_rst.rd_data_b",  rd_data_b, 64'h0);
    chk("async_rst.rd_valid_b", 64'(rd_valid_b), 64'h0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    step(0, 0, 0, 2'b11, 3, 3);

    // Fill and read back, ports sweeping in opposite directions.
    for (int i = 0; i < 8; i++) step(1, i, 32'h11111111 * (i + 1), 2'b00, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 2'b11, i, 7 - i);

    // Bypass, and concurrent read of a different entry.
    step(1, 5, 32'hAAAA0000, 2'b00, 0, 0);
    step(1, 5, 32'h5555FFFF, 2'b11, 5, 5);
    step(1, 5, 32'h0BADF00D, 2'b11, 5, 4);
    step(0, 0, 0, 2'b11, 5, 4);

    // Entry 0 write with same-cycle and later read.
    step(1, 0, 32'h12345678, 2'b11, 0, 0);
    step(0, 0, 0, 2'b11, 0, 0);

    // Out-of-range write and reads (out of range for dut_b only).
    step(1, 7, 32'hFFFF0000, 2'b11, 6, 7);
    step(0, 0, 0, 2'b11, 7, 5);
    step(0, 0, 0, 2'b00, 0, 0);

    // Hold: data persists while rd_en is low, even as the entry changes.
    step(1, 2, 32'h0000CAFE, 2'b00, 0, 0);
    step(0, 0, 0, 2'b11, 2, 2);
    for (int i = 0; i < 3; i++) step(1, 2, 32'h1000 + i, 2'b00, 2, 2);
    step(0, 0, 0, 2'b11, 2, 2);

    // Random traffic, addresses biased toward a small range for bypass hits.
    for (int n = 0; n < 400; n++) begin
      int wa, r0, r1;
      wa = (n % 3 == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 7));
      r0 = (n % 3 == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 7));
      r1 = (n % 3 == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 7));
      step(1'($urandom_range(0, 1)), wa, $urandom, 2'($urandom_range(0, 3)), r0, r1);
    end
    wr_en = 1'b0; rd_en = 2'b00;

    // Drain: the monitor must consume every expected entry.
    for (int i = 0; i < 5 && (q_a.size() + q_b.size()) > 0; i++) @(negedge clk);
    #1;
    total++;
    if (q_a.size() + q_b.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d responses outstanding, expected 0", q_a.size() + q_b.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
